dwrr_ingress_queues: RTL and testbench
======================================

# dwrr_ingress_queues

Per-requestor packet ingress buffering for the DWRR arbiter. Holds one FIFO per requestor, presents each non-empty FIFO as a request (`reqs`) to the arbiter, and pops the head of the granted FIFO on the arbiter's `gnt`. It drives the single granted packet word out on a registered output port. The block sits directly upstream of the DWRR arbiter and closes the `reqs`/`gnt` loop with it.

## Interface
- `NUM_REQS`, 4, number of requestors/queues; must match the arbiter.
- `DWID`, 8, packet word width.
- `DEPTH`, 4, entries per queue; power of two, ≥2.
- `PTRWID`, `$clog2(DEPTH)`, read/write pointer width.
- `CNTWID`, `$clog2(NUM_REQS)`, requestor index width.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `push` input NUM_REQS: per-queue write strobe.
- `push_data` input NUM_REQS*DWID: queue i's data is bits `[(i+1)*DWID-1:i*DWID]`.
- `blk` input 1: block all dequeues; shared with the arbiter's `blk`.
- `gnt` input NUM_REQS: one-hot-or-zero grant from the arbiter.
- `reqs` output NUM_REQS: queue i non-empty and `blk` low; feeds the arbiter.
- `full` output NUM_REQS: queue i holds DEPTH entries.
- `out_valid` output 1: `out_data`/`out_id` carry a popped word.
- `out_data` output DWID: popped word.
- `out_id` output CNTWID: index of the queue that was popped.
- `err` output 1: sticky error flag.

## Operation
- Each queue keeps `wr_ptr`, `rd_ptr` (PTRWID bits) and `count` (PTRWID+1 bits, range 0..DEPTH). Pointers wrap modulo DEPTH.
- Push to queue i is accepted iff `push[i] & ~full[i]`. The data is written at `wr_ptr`, then `wr_ptr` increments.
- Push while full:
  - The word is dropped and `err` is set.
  - A pop of the same queue in the same cycle does not rescue the push; `full` is the only acceptance condition.
- Pop of queue i happens iff `gnt[i] & reqs[i]`. The head is read at `rd_ptr`, then `rd_ptr` increments.
- Grant to a queue whose `reqs[i]=0` (empty, or `blk` high): ignored, no pointer change, `err` set.
- More than one `gnt` bit high in a cycle: no pop at all, `err` set.
- Simultaneous accepted push and pop on the same queue: `count` is unchanged and both pointers advance.
- No empty-queue bypass: a word pushed in cycle N raises `reqs` in cycle N+1 at the earliest.
- `reqs[i] = (count[i]!=0) & ~blk` is combinational from registered state plus `blk`. It must not depend on `gnt` or `push`, so no combinational loop forms with the arbiter.
- `full[i] = (count[i]==DEPTH)` is purely registered state.
- `err` stays set until reset.

## Timing
- Reset values: all pointers and counts 0, so `reqs=0` and `full=0`. Also `out_valid=0`, `out_data=0`, `out_id=0`, `err=0`. Storage contents are don't-care.
- Reset asserted mid-operation flushes all queues on that edge. Pushes and grants in a reset cycle are ignored and do not set `err`.
- Pop latency is 1 cycle: a pop in cycle N gives `out_valid=1` with that word and `out_id=i` in cycle N+1.
- When no pop occurs, `out_valid` deasserts the next cycle; `out_data`/`out_id` hold their last values.
- There is no output backpressure; downstream always accepts.
- Back-to-back pops of the same queue in consecutive cycles are supported at full rate.

## Structure
- Shared package `dwrr_pkg` holds the `NUM_REQS` default, `DWID` default, and the `CNTWID` derivation, reused by the arbiter.
- One sub-module, `pkt_fifo`, instantiated NUM_REQS times in a generate loop:
  - inputs: clk, rst, push, push_data, pop;
  - outputs: head_data, empty, full, ovf;
  - registered storage array with pointer/count logic.
- The top level contains the grant-validation logic, the one-hot-to-index encoder for `out_id`, the head mux, and the output and `err` registers.

## Test plan
- **Reset:** after reset, expect `reqs=0000`, `full=0000`, `out_valid=0`, `err=0`.
- **Single push/pop:** push 0x5A to queue 2 in cycle 0; expect `reqs=0100` in cycle 1. Assert `gnt=0100` in cycle 1; expect `out_valid=1`, `out_data=0x5A`, `out_id=2` in cycle 2, and `reqs=0000`.
- **Fill and overflow:** push 0x01..0x05 into queue 0. Expect `full[0]=1` after the 4th push, the 5th word dropped, and `err=1`. Grant queue 0 four cycles; expect 0x01..0x04 in order, then `reqs[0]=0`.
- **Block:** queue 1 holds 0x33 and `blk=1`; expect `reqs=0000`. Asserting `gnt=0010` gives no pop and `err=1`. With `blk=0` and `gnt=0010`, expect 0x33 out the following cycle.
- **Concurrency and wrap:** hold queue 3 at count 2 with push and pop every cycle for 10 cycles. Expect the count to stay 2, FIFO order preserved across pointer wrap, and `err=0`.
- **Illegal grant / reset mid-stream:** `gnt=0011` gives no pop and `err=1`. Asserting `rst` with queues non-empty gives `reqs=0000` and `err=0` on the next cycle.

Source files
------------

// File: rtl/dwrr_pkg.sv
// Shared definitions for the DWRR arbiter and its ingress queues.
// Holds the default requestor count and word width plus the
// requestor-index width derivation used by both blocks.
package dwrr_pkg;

  localparam int unsigned NUM_REQS_DEF = 4;
  localparam int unsigned DWID_DEF     = 8;

  // Width of a requestor index; a single requestor still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dwrr_ingress_queues_if.sv
// Handshake bundle between the ingress queues and their environment.
//   push/push_data : per-queue write strobes and packed write data
//   blk/gnt        : dequeue block and arbiter grant
//   reqs/full      : per-queue request and full status
//   out_*          : registered popped word, its queue index, valid
//   err            : sticky error flag
// master = producer/arbiter side, slave = the queue block.
interface dwrr_ingress_queues_if
  import dwrr_pkg::*;
#(
  parameter int unsigned NUM_REQS = NUM_REQS_DEF,
  parameter int unsigned DWID     = DWID_DEF,
  parameter int unsigned CNTWID   = idx_width(NUM_REQS)
);
  logic [NUM_REQS-1:0]      push;
  logic [NUM_REQS*DWID-1:0] push_data;
  logic                     blk;
  logic [NUM_REQS-1:0]      gnt;
  logic [NUM_REQS-1:0]      reqs;
  logic [NUM_REQS-1:0]      full;
  logic                     out_valid;
  logic [DWID-1:0]          out_data;
  logic [CNTWID-1:0]        out_id;
  logic                     err;

  modport master (
    output push, push_data, blk, gnt,
    input  reqs, full, out_valid, out_data, out_id, err
  );

  modport slave (
    input  push, push_data, blk, gnt,
    output reqs, full, out_valid, out_data, out_id, err
  );
endinterface

// File: rtl/dwrr_ingress_queues_pkt_fifo.sv
// Single packet FIFO with registered storage.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write strobe (ignored when full)
//   push_data  : word to write
//   pop        : read strobe (ignored when empty)
//   head_data  : word at the read pointer
//   empty/full : occupancy status from the registered count
//   ovf        : push attempted while full
module pkt_fifo #(
  parameter int unsigned DWID   = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTRWID = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [DWID-1:0] push_data,
  input  logic            pop,
  output logic [DWID-1:0] head_data,
  output logic            empty,
  output logic            full,
  output logic            ovf
);

  localparam logic [PTRWID:0] FULL_CNT = (PTRWID+1)'(DEPTH);

  logic [DWID-1:0]   mem_q [DEPTH];
  logic [PTRWID-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRWID-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRWID:0]   count_q,  count_d;
  logic              wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign ovf   = push & full;

  // Acceptance depends only on registered fullness: a same-cycle pop
  // never makes room for a push.
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  assign head_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTRWID'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTRWID'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (PTRWID+1)'(1);
      2'b01:   count_d = count_q - (PTRWID+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are only visible once written.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dwrr_ingress_queues.sv
// Per-requestor ingress buffering for the DWRR arbiter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of dwrr_ingress_queues_if
//              (push/push_data/blk/gnt in; reqs/full/out_*/err out)
// Each queue presents a request while non-empty and not blocked; a
// valid one-hot grant pops the head, which appears on the registered
// output one cycle later together with the queue index.
module dwrr_ingress_queues
  import dwrr_pkg::*;
#(
  parameter int unsigned NUM_REQS = NUM_REQS_DEF,
  parameter int unsigned DWID     = DWID_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTRWID   = $clog2(DEPTH),
  parameter int unsigned CNTWID   = idx_width(NUM_REQS)
) (
  input  logic                  clk,
  input  logic                  rst,
  dwrr_ingress_queues_if.slave  bus
);

  logic [NUM_REQS-1:0] empty, full, ovf, pop, reqs;
  logic [DWID-1:0]     head [NUM_REQS];
  logic                multi_gnt, stray_gnt;

  logic [CNTWID-1:0]   pop_idx;
  logic [DWID-1:0]     pop_data;
  logic                pop_any;

  logic                out_valid_q, out_valid_d;
  logic [DWID-1:0]     out_data_q,  out_data_d;
  logic [CNTWID-1:0]   out_id_q,    out_id_d;
  logic                err_q,       err_d;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_q
    pkt_fifo #(
      .DWID   (DWID),
      .DEPTH  (DEPTH),
      .PTRWID (PTRWID)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.push[g]),
      .push_data (bus.push_data[g*DWID +: DWID]),
      .pop       (pop[g]),
      .head_data (head[g]),
      .empty     (empty[g]),
      .full      (full[g]),
      .ovf       (ovf[g])
    );
  end

  // Requests come only from registered state and blk, never from gnt,
  // so no combinational loop closes through the arbiter.
  assign reqs = ~empty & {NUM_REQS{~bus.blk}};

  // gnt & (gnt-1) clears the lowest set bit; anything left means >1 bit.
  assign multi_gnt = |(bus.gnt & (bus.gnt - NUM_REQS'(1)));
  assign stray_gnt = |(bus.gnt & ~reqs);
  assign pop       = multi_gnt ? '0 : (bus.gnt & reqs);

  // pop is one-hot-or-zero here, so a plain scan is a clean encoder.
  always_comb begin
    pop_idx  = '0;
    pop_data = '0;
    pop_any  = |pop;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (pop[i]) begin
        pop_idx  = CNTWID'(i);
        pop_data = head[i];
      end
    end
  end

  always_comb begin
    out_valid_d = pop_any;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (pop_any) begin
      out_data_d = pop_data;
      out_id_d   = pop_idx;
    end
    err_d = err_q | multi_gnt | stray_gnt | (|ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      err_q       <= err_d;
    end
  end

  assign bus.reqs      = reqs;
  assign bus.full      = full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_dwrr_ingress_queues.sv
module tb_dwrr_ingress_queues;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dwrr_ingress_queues_if #(.NUM_REQS(N), .DWID(DW)) bus ();

  dwrr_ingress_queues #(
    .NUM_REQS (N),
    .DWID     (DW),
    .DEPTH    (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one plain queue per requestor plus output state.
  logic [7:0] mq [N][$];
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_id;
  logic       m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_reqs(input logic b);
    logic [3:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() != 0) && !b;
    return r;
  endfunction

  function automatic logic [3:0] m_full();
    logic [3:0] f;
    for (int i = 0; i < N; i++) f[i] = (mq[i].size() == D);
    return f;
  endfunction

  // Apply one cycle of inputs, advance the model, then compare all
  // outputs against it just after the clock edge.
  task automatic step(input logic r, input logic [3:0] p, input logic [31:0] pd,
                      input logic b, input logic [3:0] g);
    int sizes[N];
    int ng;
    logic [3:0] rq;
    rst           = r;
    bus.push      = p;
    bus.push_data = pd;
    bus.blk       = b;
    bus.gnt       = g;
    if (r) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_valid = 1'b0; m_data = '0; m_id = '0; m_err = 1'b0;
    end else begin
      rq = m_reqs(b);
      for (int i = 0; i < N; i++) sizes[i] = mq[i].size();
      ng = $countones(g);
      m_valid = 1'b0;
      if (ng > 1) m_err = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (g[i] && !rq[i]) m_err = 1'b1;
        if (ng == 1 && g[i] && rq[i]) begin
          m_valid = 1'b1;
          m_data  = mq[i].pop_front();
          m_id    = 2'(i);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (p[i]) begin
          if (sizes[i] == D) m_err = 1'b1;
          else mq[i].push_back(pd[i*8 +: 8]);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("reqs",      32'(bus.reqs),      32'(m_reqs(b)));
    chk("full",      32'(bus.full),      32'(m_full()));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(bus.out_data), 32'(m_data));
      chk("out_id",   32'(bus.out_id),   32'(m_id));
    end
    chk("err",       32'(bus.err),       32'(m_err));
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  p;
    logic [31:0] pd;
    logic        b;
    logic [3:0]  g;
    logic [3:0]  e_reqs;
    logic [3:0]  e_full;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_id;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [3:0]  p, g, rq;
    logic [31:0] pd;
    logic        b, r;
    int          k;

    rst = 1'b1;
    bus.push = '0; bus.push_data = '0; bus.blk = 1'b0; bus.gnt = '0;

    // Directed vectors: reset, single push/pop, block, illegal grant,
    // reset with non-empty queues.
    vecs.push_back('{1, 4'b0000, 32'h0,        0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 2'd0, 0});
    vecs.push_back('{0, 4'b0100, 32'h005A0000, 0, 4'b0000, 4'b0100, 4'b0000, 0, 8'h00, 2'd0, 0});
    vecs.push_back('{0, 4'b0000, 32'h0,        0, 4'b0100, 4'b0000, 4'b0000, 1, 8'h5A, 2'd2, 0});
    vecs.push_back('{0, 4'b0000, 32'h0,        0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h5A, 2'd2, 0});
    vecs.push_back('{0, 4'b0010, 32'h00003300, 0, 4'b0000, 4'b0010, 4'b0000, 0, 8'h5A, 2'd2, 0});
    vecs.push_back('{0, 4'b0000, 32'h0,        1, 4'b0000, 4'b0000, 4'b0000, 0, 8'h5A, 2'd2, 0});
    vecs.push_back('{0, 4'b0000, 32'h0,        1, 4'b0010, 4'b0000, 4'b0000, 0, 8'h5A, 2'd2, 1});
    vecs.push_back('{0, 4'b0000, 32'h0,        0, 4'b0010, 4'b0000, 4'b0000, 1, 8'h33, 2'd1, 1});
    vecs.push_back('{0, 4'b0000, 32'h0,        0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h33, 2'd1, 1});
    vecs.push_back('{1, 4'b0000, 32'h0,        0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 2'd0, 0});
    vecs.push_back('{0, 4'b0011, 32'h0000BBAA, 0, 4'b0000, 4'b0011, 4'b0000, 0, 8'h00, 2'd0, 0});
    vecs.push_back('{0, 4'b0000, 32'h0,        0, 4'b0011, 4'b0011, 4'b0000, 0, 8'h00, 2'd0, 1});
    vecs.push_back('{1, 4'b0011, 32'h0000CCDD, 0, 4'b1000, 4'b0000, 4'b0000, 0, 8'h00, 2'd0, 0});

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].p, vecs[i].pd, vecs[i].b, vecs[i].g);
      chk($sformatf("v%0d_reqs", i),      32'(bus.reqs),      32'(vecs[i].e_reqs));
      chk($sformatf("v%0d_full", i),      32'(bus.full),      32'(vecs[i].e_full));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_out_data", i),  32'(bus.out_data),  32'(vecs[i].e_od));
      chk($sformatf("v%0d_out_id", i),    32'(bus.out_id),    32'(vecs[i].e_id));
      chk($sformatf("v%0d_err", i),       32'(bus.err),       32'(vecs[i].e_err));
    end

    // Fill queue 0 and overflow it, then drain in order.
    step(1, '0, '0, 0, '0);
    for (k = 1; k <= 5; k++) begin
      step(0, 4'b0001, 32'(k), 0, '0);
      if (k == 4) begin
        chk("fill_full0", 32'(bus.full[0]), 32'd1);
        chk("fill_err_before_ovf", 32'(bus.err), 32'd0);
      end
    end
    chk("ovf_err", 32'(bus.err), 32'd1);
    for (k = 1; k <= 4; k++) begin
      step(0, '0, '0, 0, 4'b0001);
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_data",  32'(bus.out_data),  32'(k));
      chk("drain_id",    32'(bus.out_id),    32'd0);
    end
    chk("drain_empty", 32'(bus.reqs[0]), 32'd0);

    // Queue 3 held at two entries with push+pop every cycle across wrap.
    step(1, '0, '0, 0, '0);
    step(0, 4'b1000, 32'h10000000, 0, '0);
    step(0, 4'b1000, 32'h11000000, 0, '0);
    for (k = 0; k < 10; k++) begin
      step(0, 4'b1000, {8'(8'h12 + k), 24'h0}, 0, 4'b1000);
      chk("conc_data", 32'(bus.out_data), 32'(8'h10 + k));
      chk("conc_full", 32'(bus.full[3]),  32'd0);
      chk("conc_reqs", 32'(bus.reqs[3]),  32'd1);
    end
    chk("conc_err", 32'(bus.err), 32'd0);
    step(0, '0, '0, 0, 4'b1000);
    chk("conc_tail0", 32'(bus.out_data), 32'h1A);
    step(0, '0, '0, 0, 4'b1000);
    chk("conc_tail1", 32'(bus.out_data), 32'h1B);
    chk("conc_empty", 32'(bus.reqs[3]), 32'd0);

    // Randomized traffic against the model.
    step(1, '0, '0, 0, '0);
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(0, 99) < 2);
      p  = 4'($urandom);
      pd = $urandom;
      b  = ($urandom_range(0, 9) == 0);
      rq = m_reqs(b);
      g  = '0;
      if ($urandom_range(0, 99) < 4) begin
        g = 4'($urandom);
      end else if (rq != 0 && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, N - 1);
        while (!rq[k]) k = (k + 1) % N;
        g[k] = 1'b1;
      end
      step(r, p, pd, b, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
